// File: rtl/rr_pri_enc.sv
// Registered priority encoder / arbiter front end: grants the first active
// request at or after a rotating pointer and holds it until acknowledged.
module rr_pri_enc #(
   parameter int IN  = 16,
   parameter int OUT = $clog2(IN),
   parameter bit ACT = 1'b1,
   parameter bit RR  = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [IN-1:0]  req,
   input  logic           ack,
   output logic           valid,
   output logic [OUT-1:0] out,
   output logic [IN-1:0]  grant
);

   // Handshake: a grant is offered while valid=1 and is consumed on any
   // rising edge where ack=1; ack is ignored while valid=0.
   logic           r_valid;
   logic [OUT-1:0] r_out;
   logic [IN-1:0]  r_grant;
   logic [OUT-1:0] r_ptr;

   logic [IN-1:0]  w_r;
   logic           w_accept;
   logic           w_hold;
   logic [OUT-1:0] w_np;
   logic [OUT-1:0] w_start;
   logic           w_found;
   logic [OUT-1:0] w_k;
   logic [IN-1:0]  w_gnt;

   assign w_r      = ACT ? req : ~req;
   assign w_accept = r_valid & ack;
   assign w_hold   = r_valid & ~ack & w_r[r_out];
   assign w_np     = (r_out == OUT'(IN - 1)) ? '0 : r_out + OUT'(1);
   assign w_start  = w_accept ? (RR ? w_np : '0) : r_ptr;

   // Circular scan from w_start; the first hit wins.
   always_comb begin
      int             j;
      logic [OUT-1:0] idx;
      j       = 0;
      idx     = '0;
      w_found = 1'b0;
      w_k     = '0;
      w_gnt   = '0;
      for (int i = 0; i < IN; i++) begin
         j = int'(w_start) + i;
         if (j >= IN) j = j - IN;
         idx = OUT'(j);
         if (!w_found && w_r[idx]) begin
            w_found    = 1'b1;
            w_k        = idx;
            w_gnt[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_out   <= '0;
         r_grant <= '0;
         r_ptr   <= '0;
      end else if (!w_hold) begin
         if (w_accept && RR) r_ptr <= w_np;
         r_valid <= w_found;
         r_out   <= w_k;
         r_grant <= w_gnt;
      end
   end

   assign valid = r_valid;
   assign out   = r_out;
   assign grant = r_grant;

endmodule

// File: tb/tb_rr_pri_enc.sv
// Directed bench for rr_pri_enc: round-robin, active-low, fixed-priority and
// non-power-of-two configurations side by side on one clock.
module tb_rr_pri_enc;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // a: IN=16 RR High, b: IN=16 RR Low, c/d: IN=8 fixed High/Low, e: IN=5 RR High
   logic [15:0] req_a, grant_a, req_b, grant_b;
   logic [7:0]  req_c, grant_c, req_d, grant_d;
   logic [4:0]  req_e, grant_e;
   logic [3:0]  out_a, out_b;
   logic [2:0]  out_c, out_d, out_e;
   logic        ack_a, ack_b, ack_c, ack_d, ack_e;
   logic        valid_a, valid_b, valid_c, valid_d, valid_e;

   rr_pri_enc #(.IN(16), .ACT(1'b1), .RR(1'b1)) u_a (
      .clk(clk), .reset(reset), .req(req_a), .ack(ack_a),
      .valid(valid_a), .out(out_a), .grant(grant_a));
   rr_pri_enc #(.IN(16), .ACT(1'b0), .RR(1'b1)) u_b (
      .clk(clk), .reset(reset), .req(req_b), .ack(ack_b),
      .valid(valid_b), .out(out_b), .grant(grant_b));
   rr_pri_enc #(.IN(8), .ACT(1'b1), .RR(1'b0)) u_c (
      .clk(clk), .reset(reset), .req(req_c), .ack(ack_c),
      .valid(valid_c), .out(out_c), .grant(grant_c));
   rr_pri_enc #(.IN(8), .ACT(1'b0), .RR(1'b0)) u_d (
      .clk(clk), .reset(reset), .req(req_d), .ack(ack_d),
      .valid(valid_d), .out(out_d), .grant(grant_d));
   rr_pri_enc #(.IN(5), .ACT(1'b1), .RR(1'b1)) u_e (
      .clk(clk), .reset(reset), .req(req_e), .ack(ack_e),
      .valid(valid_e), .out(out_e), .grant(grant_e));

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference lowest-active-bit encoder for 8 lines: {found, index}.
   function automatic logic [3:0] pe8(input logic [7:0] r);
      logic [3:0] res;
      res = 4'b0000;
      for (int k = 7; k >= 0; k--) if (r[k]) res = {1'b1, 3'(k)};
      return res;
   endfunction

   task automatic test_reset();
      logic [20:0] exp;
      req_a = 16'hFFFF; ack_a = 1'b0;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_vec++;
         if ({valid_a, out_a, grant_a} !== 21'd0) begin
            n_miss++;
            $display("FAIL reset_hold cycle %0d: got v=%0b o=%0d g=%h want v=0 o=0 g=0000",
                     c, valid_a, out_a, grant_a);
         end
      end
      reset = 1'b0;
      step();
      exp = {1'b1, 4'd0, 16'h0001};
      n_vec++;
      if ({valid_a, out_a, grant_a} !== exp) begin
         n_miss++;
         $display("FAIL reset_first_grant: got v=%0b o=%0d g=%h want v=1 o=0 g=0001",
                  valid_a, out_a, grant_a);
      end
   endtask

   task automatic test_rr_sweep();
      logic [15:0] one = 16'h0001;
      logic [3:0]  e;
      ack_a = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         e = 4'(i % 16);
         n_vec++;
         if ({valid_a, out_a, grant_a} !== {1'b1, e, one << e}) begin
            n_miss++;
            $display("FAIL rr_sweep step %0d: got v=%0b o=%0d g=%h want o=%0d",
                     i, valid_a, out_a, grant_a, e);
         end
      end
      req_a = 16'h8001;
      for (int i = 0; i < 4; i++) begin
         step();
         e = (i % 2 == 0) ? 4'd15 : 4'd0;
         n_vec++;
         if ({valid_a, out_a, grant_a} !== {1'b1, e, one << e}) begin
            n_miss++;
            $display("FAIL rr_8001 step %0d: got v=%0b o=%0d g=%h want o=%0d",
                     i, valid_a, out_a, grant_a, e);
         end
      end
   endtask

   task automatic test_hold_rotate();
      req_a = 16'h0005; ack_a = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         n_vec++;
         if ({valid_a, out_a, grant_a} !== {1'b1, 4'd0, 16'h0001}) begin
            n_miss++;
            $display("FAIL hold0 cycle %0d: got v=%0b o=%0d g=%h want o=0", c, valid_a, out_a, grant_a);
         end
      end
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if ({valid_a, out_a, grant_a} !== {1'b1, 4'd2, 16'h0004}) begin
            n_miss++;
            $display("FAIL rotate_to2 cycle %0d: got v=%0b o=%0d g=%h want o=2", c, valid_a, out_a, grant_a);
         end
         step();
      end
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      n_vec++;
      if ({valid_a, out_a, grant_a} !== {1'b1, 4'd0, 16'h0001}) begin
         n_miss++;
         $display("FAIL rotate_to0: got v=%0b o=%0d g=%h want o=0", valid_a, out_a, grant_a);
      end
   endtask

   task automatic test_withdraw();
      // Reset while a grant is held, with no ack.
      reset = 1'b1; req_a = 16'h0000;
      step();
      n_vec++;
      if ({valid_a, out_a, grant_a} !== 21'd0) begin
         n_miss++;
         $display("FAIL reset_mid_grant: got v=%0b o=%0d g=%h want v=0", valid_a, out_a, grant_a);
      end
      reset = 1'b0;
      req_a = 16'h0008;
      step();
      step();
      n_vec++;
      if ({valid_a, out_a, grant_a} !== {1'b1, 4'd3, 16'h0008}) begin
         n_miss++;
         $display("FAIL withdraw_setup: got v=%0b o=%0d g=%h want o=3", valid_a, out_a, grant_a);
      end
      req_a = 16'h0000;
      step();
      n_vec++;
      if ({valid_a, out_a, grant_a} !== 21'd0) begin
         n_miss++;
         $display("FAIL withdraw_drop: got v=%0b o=%0d g=%h want v=0", valid_a, out_a, grant_a);
      end
      req_a = 16'h0011;
      step();
      n_vec++;
      if ({valid_a, out_a, grant_a} !== {1'b1, 4'd0, 16'h0001}) begin
         n_miss++;
         $display("FAIL withdraw_ptr_kept: got v=%0b o=%0d g=%h want o=0", valid_a, out_a, grant_a);
      end
   endtask

   task automatic test_active_low();
      logic [15:0] one = 16'h0001;
      req_b = 16'hFFFF; ack_b = 1'b0;
      step();
      n_vec++;
      if ({valid_b, out_b, grant_b} !== 21'd0) begin
         n_miss++;
         $display("FAIL low_none: got v=%0b o=%0d g=%h want v=0", valid_b, out_b, grant_b);
      end
      for (int i = 0; i < 16; i++) begin
         req_b = 16'hFFFF ^ (one << i);
         step();
         n_vec++;
         if ({valid_b, out_b, grant_b} !== {1'b1, 4'(i), one << i}) begin
            n_miss++;
            $display("FAIL low_single %0d: got v=%0b o=%0d g=%h want o=%0d", i, valid_b, out_b, grant_b, i);
         end
      end
   endtask

   task automatic test_fixed();
      logic [7:0]  v, one;
      logic [3:0]  pc, pd;
      logic [11:0] ec, ed;
      one = 8'h01;
      ack_c = 1'b1; ack_d = 1'b1;
      for (int n = 0; n < 256; n++) begin
         v = 8'(n);
         req_c = v; req_d = v;
         step();
         pc = pe8(v);
         pd = pe8(~v);
         ec = pc[3] ? {1'b1, pc[2:0], one << pc[2:0]} : 12'd0;
         ed = pd[3] ? {1'b1, pd[2:0], one << pd[2:0]} : 12'd0;
         n_vec++;
         if ({valid_c, out_c, grant_c} !== ec) begin
            n_miss++;
            $display("FAIL fixed_high req=%h: got %h want %h", v, {valid_c, out_c, grant_c}, ec);
         end
         n_vec++;
         if ({valid_d, out_d, grant_d} !== ed) begin
            n_miss++;
            $display("FAIL fixed_low req=%h: got %h want %h", v, {valid_d, out_d, grant_d}, ed);
         end
      end
      req_c = 8'h81;
      for (int c = 0; c < 6; c++) begin
         step();
         n_vec++;
         if ({valid_c, out_c, grant_c} !== {1'b1, 3'd0, 8'h01}) begin
            n_miss++;
            $display("FAIL fixed_81 cycle %0d: got v=%0b o=%0d g=%h want o=0", c, valid_c, out_c, grant_c);
         end
      end
   endtask

   task automatic test_wrap_npot();
      logic [4:0] one = 5'h01;
      logic [2:0] e;
      req_e = 5'h1F; ack_e = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         e = 3'(i % 5);
         n_vec++;
         if ({valid_e, out_e, grant_e} !== {1'b1, e, one << e}) begin
            n_miss++;
            $display("FAIL npot_wrap step %0d: got v=%0b o=%0d g=%h want o=%0d", i, valid_e, out_e, grant_e, e);
         end
      end
   endtask

   initial begin
      req_a = 16'h0000; ack_a = 1'b0;
      req_b = 16'hFFFF; ack_b = 1'b0;
      req_c = 8'h00;    ack_c = 1'b0;
      req_d = 8'hFF;    ack_d = 1'b0;
      req_e = 5'h1F;    ack_e = 1'b0;
      #1;
      test_reset();
      test_rr_sweep();
      test_hold_rotate();
      test_withdraw();
      test_active_low();
      test_fixed();
      test_wrap_npot();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
